// File: rtl/ps2_kbd_pkg.sv
// rtl/ps2_kbd_pkg.sv - shared constants and types for the PS/2 keyboard ASCII decoder
package ps2_kbd_pkg;

    // Scan code prefixes
    localparam logic [7:0] SC_EXT      = 8'hE0;
    localparam logic [7:0] SC_BRK      = 8'hF0;

    // Modifier and extended-key scan codes
    localparam logic [7:0] SC_SHIFT_L  = 8'h12;
    localparam logic [7:0] SC_SHIFT_R  = 8'h59;
    localparam logic [7:0] SC_CAPS     = 8'h58;
    localparam logic [7:0] SC_KP_ENTER = 8'h5A;
    localparam logic [7:0] SC_KP_SLASH = 8'h4A;

    // ASCII constants
    localparam logic [7:0] ASCII_CR       = 8'h0D;
    localparam logic [7:0] ASCII_BS       = 8'h08;
    localparam logic [7:0] ASCII_SP       = 8'h20;
    localparam logic [7:0] ASCII_TAB      = 8'h09;
    localparam logic [7:0] ASCII_ESC      = 8'h1B;
    localparam logic [7:0] ASCII_SLASH    = 8'h2F;
    localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } prefix_state_t;

endpackage

// File: rtl/ps2_kbd_ascii_fifo_lut.sv
// rtl/ps2_kbd_ascii_fifo_lut.sv - combinational US-layout set-2 scan code to ASCII table
//
// Ports:
//   i_scan_code  - make code (non-prefixed)
//   o_base       - unshifted character; letters are stored uppercase
//   o_shifted    - shifted character (equals o_base for letters/controls)
//   o_is_letter  - 1 for A..Z
//   o_valid      - 1 when the code maps to a printable/control character
module scan2ascii_lut
    import ps2_kbd_pkg::*;
(
    input  logic [7:0] i_scan_code,
    output logic [7:0] o_base,
    output logic [7:0] o_shifted,
    output logic       o_is_letter,
    output logic       o_valid
);

    logic [7:0] w_b;
    logic [7:0] w_s;
    logic       w_l;
    logic       w_v;

    always_comb begin
        w_b = 8'h00;
        w_s = 8'h00;
        w_l = 1'b0;
        w_v = 1'b1;
        case (i_scan_code)
            8'h1C: begin w_b = "A"; w_l = 1'b1; end
            8'h32: begin w_b = "B"; w_l = 1'b1; end
            8'h21: begin w_b = "C"; w_l = 1'b1; end
            8'h23: begin w_b = "D"; w_l = 1'b1; end
            8'h24: begin w_b = "E"; w_l = 1'b1; end
            8'h2B: begin w_b = "F"; w_l = 1'b1; end
            8'h34: begin w_b = "G"; w_l = 1'b1; end
            8'h33: begin w_b = "H"; w_l = 1'b1; end
            8'h43: begin w_b = "I"; w_l = 1'b1; end
            8'h3B: begin w_b = "J"; w_l = 1'b1; end
            8'h42: begin w_b = "K"; w_l = 1'b1; end
            8'h4B: begin w_b = "L"; w_l = 1'b1; end
            8'h3A: begin w_b = "M"; w_l = 1'b1; end
            8'h31: begin w_b = "N"; w_l = 1'b1; end
            8'h44: begin w_b = "O"; w_l = 1'b1; end
            8'h4D: begin w_b = "P"; w_l = 1'b1; end
            8'h15: begin w_b = "Q"; w_l = 1'b1; end
            8'h2D: begin w_b = "R"; w_l = 1'b1; end
            8'h1B: begin w_b = "S"; w_l = 1'b1; end
            8'h2C: begin w_b = "T"; w_l = 1'b1; end
            8'h3C: begin w_b = "U"; w_l = 1'b1; end
            8'h2A: begin w_b = "V"; w_l = 1'b1; end
            8'h1D: begin w_b = "W"; w_l = 1'b1; end
            8'h22: begin w_b = "X"; w_l = 1'b1; end
            8'h35: begin w_b = "Y"; w_l = 1'b1; end
            8'h1A: begin w_b = "Z"; w_l = 1'b1; end
            8'h45: begin w_b = "0"; w_s = ")"; end
            8'h16: begin w_b = "1"; w_s = "!"; end
            8'h1E: begin w_b = "2"; w_s = "@"; end
            8'h26: begin w_b = "3"; w_s = "#"; end
            8'h25: begin w_b = "4"; w_s = "$"; end
            8'h2E: begin w_b = "5"; w_s = "%"; end
            8'h36: begin w_b = "6"; w_s = "^"; end
            8'h3D: begin w_b = "7"; w_s = "&"; end
            8'h3E: begin w_b = "8"; w_s = "*"; end
            8'h46: begin w_b = "9"; w_s = "("; end
            8'h0E: begin w_b = 8'h60; w_s = "~"; end
            8'h4E: begin w_b = "-"; w_s = "_"; end
            8'h55: begin w_b = "="; w_s = "+"; end
            8'h54: begin w_b = "["; w_s = "{"; end
            8'h5B: begin w_b = "]"; w_s = "}"; end
            8'h5D: begin w_b = "\\"; w_s = "|"; end
            8'h4C: begin w_b = ";"; w_s = ":"; end
            8'h52: begin w_b = "'"; w_s = "\""; end
            8'h41: begin w_b = ","; w_s = "<"; end
            8'h49: begin w_b = "."; w_s = ">"; end
            8'h4A: begin w_b = "/"; w_s = "?"; end
            8'h5A: begin w_b = ASCII_CR;  w_s = ASCII_CR;  end
            8'h66: begin w_b = ASCII_BS;  w_s = ASCII_BS;  end
            8'h29: begin w_b = ASCII_SP;  w_s = ASCII_SP;  end
            8'h0D: begin w_b = ASCII_TAB; w_s = ASCII_TAB; end
            8'h76: begin w_b = ASCII_ESC; w_s = ASCII_ESC; end
            default: w_v = 1'b0;
        endcase
    end

    assign o_base      = w_b;
    assign o_shifted   = w_l ? w_b : w_s;
    assign o_is_letter = w_l;
    assign o_valid     = w_v;

endmodule

// File: rtl/ps2_kbd_ascii_fifo.sv
// rtl/ps2_kbd_ascii_fifo.sv - stateful PS/2 decoder with Shift/Caps handling and FWFT output FIFO
//
// Ports:
//   clk, reset                - clock, synchronous active-high reset
//   scan_code, scan_done_tick - received byte and its one-cycle strobe
//   rd_en                     - pop FIFO head (ignored when empty)
//   ascii_out, empty, full    - FIFO head (0x00 when empty) and status
//   overflow                  - sticky: a character was dropped on a full FIFO
//   shift_st, caps_st         - modifier state
module ps2_kbd_ascii_fifo
    import ps2_kbd_pkg::*;
#(
    parameter int W_ADDR  = 3,
    parameter bit CASE_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_done_tick,
    input  logic       rd_en,
    output logic [7:0] ascii_out,
    output logic       empty,
    output logic       full,
    output logic       overflow,
    output logic       shift_st,
    output logic       caps_st
);

    localparam int DEPTH = 1 << W_ADDR;
    localparam logic [W_ADDR:0] FULL_COUNT = {1'b1, {W_ADDR{1'b0}}};

    prefix_state_t r_state, w_next_state;
    logic w_make, w_brk, w_ext_make;

    logic r_shift_l, r_shift_r, r_caps, r_caps_held;

    logic [7:0]        r_mem [DEPTH];
    logic [W_ADDR-1:0] r_wr_ptr, r_rd_ptr;
    logic [W_ADDR:0]   r_count;
    logic              r_overflow;

    logic [7:0] w_base, w_shifted;
    logic       w_is_letter, w_valid;
    logic       w_upper, w_is_mod;
    logic       w_push, w_do_push, w_do_pop;
    logic [7:0] w_char;

    scan2ascii_lut u_lut (
        .i_scan_code (scan_code),
        .o_base      (w_base),
        .o_shifted   (w_shifted),
        .o_is_letter (w_is_letter),
        .o_valid     (w_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Prefix decoding; a byte arriving in BRK is always consumed as the
    // broken key, so E0/F0 there just fall out of the modifier compare.
    always_comb begin
        w_next_state = r_state;
        w_make       = 1'b0;
        w_brk        = 1'b0;
        w_ext_make   = 1'b0;
        if (scan_done_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (scan_code == SC_EXT)      w_next_state = ST_EXT;
                    else if (scan_code == SC_BRK) w_next_state = ST_BRK;
                    else                          w_make = 1'b1;
                end
                ST_EXT: begin
                    if (scan_code == SC_BRK) begin
                        w_next_state = ST_EXT_BRK;
                    end else begin
                        w_ext_make   = 1'b1;
                        w_next_state = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    w_brk        = 1'b1;
                    w_next_state = ST_IDLE;
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    assign shift_st = r_shift_l | r_shift_r;
    assign caps_st  = r_caps;
    assign w_is_mod = (scan_code == SC_SHIFT_L) || (scan_code == SC_SHIFT_R) ||
                      (scan_code == SC_CAPS);
    assign w_upper  = CASE_EN ? (shift_st ^ caps_st) : 1'b1;

    always_comb begin
        w_push = 1'b0;
        w_char = 8'h00;
        if (w_make && !w_is_mod && w_valid) begin
            w_push = 1'b1;
            if (w_is_letter)
                w_char = w_upper ? w_base : (w_base + ASCII_CASE_OFS);
            else
                w_char = (CASE_EN && shift_st) ? w_shifted : w_base;
        end else if (w_ext_make) begin
            if (scan_code == SC_KP_ENTER) begin
                w_push = 1'b1;
                w_char = ASCII_CR;
            end else if (scan_code == SC_KP_SLASH) begin
                w_push = 1'b1;
                w_char = ASCII_SLASH;
            end
        end
    end

    // Caps toggles only on the first make; typematic repeats see r_caps_held.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift_l   <= 1'b0;
            r_shift_r   <= 1'b0;
            r_caps      <= 1'b0;
            r_caps_held <= 1'b0;
        end else if (w_make) begin
            if (scan_code == SC_SHIFT_L) r_shift_l <= 1'b1;
            if (scan_code == SC_SHIFT_R) r_shift_r <= 1'b1;
            if (scan_code == SC_CAPS) begin
                if (!r_caps_held) r_caps <= ~r_caps;
                r_caps_held <= 1'b1;
            end
        end else if (w_brk) begin
            if (scan_code == SC_SHIFT_L) r_shift_l   <= 1'b0;
            if (scan_code == SC_SHIFT_R) r_shift_r   <= 1'b0;
            if (scan_code == SC_CAPS)    r_caps_held <= 1'b0;
        end
    end

    assign empty     = (r_count == '0);
    assign full      = (r_count == FULL_COUNT);
    assign overflow  = r_overflow;
    assign w_do_pop  = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_do_push = w_push && (!full || w_do_pop);
    assign ascii_out = empty ? 8'h00 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= w_char;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
            if (w_push && !w_do_push) r_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_ascii_fifo.sv
// tb/tb_ps2_kbd_ascii_fifo.sv - scoreboard testbench for ps2_kbd_ascii_fifo
module tb_ps2_kbd_ascii_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] scan_code = 8'h00;
    logic       scan_done_tick = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] ascii_out;
    logic       empty, full, overflow, shift_st, caps_st;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];
    bit auto_read = 1'b0;

    always #5 clk = ~clk;

    ps2_kbd_ascii_fifo #(.W_ADDR(3), .CASE_EN(1'b1)) dut (
        .clk            (clk),
        .reset          (reset),
        .scan_code      (scan_code),
        .scan_done_tick (scan_done_tick),
        .rd_en          (rd_en),
        .ascii_out      (ascii_out),
        .empty          (empty),
        .full           (full),
        .overflow       (overflow),
        .shift_st       (shift_st),
        .caps_st        (caps_st)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", name, act, exp);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        scan_code      = b;
        scan_done_tick = 1'b1;
        @(negedge clk);
        scan_done_tick = 1'b0;
    endtask

    task automatic drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && empty) begin
                done = 1'b1;
                break;
            end
        end
        chk(name, {7'd0, done}, 8'h01);
    endtask

    // Monitor: pops the FIFO whenever enabled and compares against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_read) begin
                if (!empty) begin
                    if (exp_q.size() == 0) chk("unexpected_output", ascii_out, 8'hxx);
                    else chk("fifo_data", ascii_out, exp_q.pop_front());
                    rd_en = 1'b1;
                end else begin
                    rd_en = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] fill [9];
        fill = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_empty", {7'd0, empty}, 8'h01);
        chk("rst_full", {7'd0, full}, 8'h00);
        chk("rst_overflow", {7'd0, overflow}, 8'h00);
        chk("rst_shift", {7'd0, shift_st}, 8'h00);
        chk("rst_caps", {7'd0, caps_st}, 8'h00);
        chk("rst_ascii", ascii_out, 8'h00);

        // 1C, F0 1C -> 'a', visible one cycle after the tick
        auto_read = 1'b1;
        exp_q.push_back(8'h61);
        @(negedge clk);
        chk("lat_empty_before", {7'd0, empty}, 8'h01);
        scan_code = 8'h1C; scan_done_tick = 1'b1;
        @(negedge clk);
        scan_done_tick = 1'b0;
        chk("lat_empty_after", {7'd0, empty}, 8'h00);
        send(8'hF0); send(8'h1C);
        drain("drain_t1");

        // Shift: 'A', '!', then 'a'
        exp_q.push_back(8'h41); exp_q.push_back(8'h21); exp_q.push_back(8'h61);
        send(8'h12);
        chk("shift_set", {7'd0, shift_st}, 8'h01);
        send(8'h1C); send(8'h16); send(8'hF0); send(8'h12);
        chk("shift_clr", {7'd0, shift_st}, 8'h00);
        send(8'h1C);
        drain("drain_t2");

        // Caps with typematic repeat
        exp_q.push_back(8'h41); exp_q.push_back(8'h31);
        send(8'h58);
        chk("caps_on", {7'd0, caps_st}, 8'h01);
        send(8'h58);
        chk("caps_repeat", {7'd0, caps_st}, 8'h01);
        send(8'hF0); send(8'h58); send(8'h1C); send(8'h16);
        send(8'h58); send(8'hF0); send(8'h58);
        chk("caps_off", {7'd0, caps_st}, 8'h00);
        drain("drain_t3");

        // Extended keys: only keypad Enter produces a character
        exp_q.push_back(8'h0D);
        send(8'hE0); send(8'h5A);
        send(8'hE0); send(8'hF0); send(8'h5A);
        send(8'hE0); send(8'h12);
        chk("fake_shift", {7'd0, shift_st}, 8'h00);
        send(8'h07);
        drain("drain_t4");

        // Fill without reads, overflow on the 9th, then push+pop while full
        auto_read = 1'b0;
        rd_en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_q.push_back(8'h61 + 8'(i));
            send(fill[i]);
            if (i == 7) begin
                chk("full_at_8", {7'd0, full}, 8'h01);
                chk("no_ovf_at_8", {7'd0, overflow}, 8'h00);
            end
        end
        chk("full_at_9", {7'd0, full}, 8'h01);
        chk("ovf_at_9", {7'd0, overflow}, 8'h01);
        @(negedge clk);
        scan_code = 8'h1D; scan_done_tick = 1'b1; rd_en = 1'b1;
        chk("pushpop_head", ascii_out, exp_q.pop_front());
        exp_q.push_back(8'h77);
        @(negedge clk);
        scan_done_tick = 1'b0; rd_en = 1'b0;
        chk("pushpop_full", {7'd0, full}, 8'h01);
        chk("pushpop_ovf", {7'd0, overflow}, 8'h01);
        auto_read = 1'b1;
        drain("drain_t5");

        // Reset between E0 and F0 discards the prefix
        auto_read = 1'b0;
        rd_en = 1'b0;
        send(8'hE0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst2_overflow", {7'd0, overflow}, 8'h00);
        chk("rst2_empty", {7'd0, empty}, 8'h01);
        auto_read = 1'b1;
        exp_q.push_back(8'h61);
        send(8'h1C);
        drain("drain_t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
